// File: rtl/route_sequencer.sv
// route_sequencer: steps through an 8-slot program of manoeuvre opcodes,
// raising one enable toward the tracking/u-turn block per step and waiting for its completion flag.
// Ports: clkus/rst (async, active-high); start/abort control; prog_we/addr/data load the program
// while idle; four completion flags in; four enables, busy/done/fault/fault_code/step out (all registered).
module route_sequencer #(
  parameter int STEP_TIMEOUT = 20000000,
  parameter int PAUSE_TIME   = 500000
) (
  input  logic       clkus,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       prog_we,
  input  logic [2:0] prog_addr,
  input  logic [2:0] prog_data,
  input  logic       end_of_track,
  input  logic       uturn_finished,
  input  logic       brake_finished,
  input  logic       reverse_finished,
  output logic       en_tracking,
  output logic       en_uturn,
  output logic       en_brake,
  output logic       en_reverse,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] step
);

  localparam int CMAX = (STEP_TIMEOUT > PAUSE_TIME) ? STEP_TIMEOUT : PAUSE_TIME;
  localparam int TW   = $clog2(CMAX + 1);
  localparam logic [TW-1:0] ONE     = TW'(1);
  localparam logic [TW-1:0] TO_LAST = TW'(STEP_TIMEOUT - 1);
  // The FETCH cycle that follows PAUSE is part of the wait, so the next
  // step's enable rises exactly PAUSE_TIME cycles after PAUSE is entered.
  localparam logic [TW-1:0] PAUSE_LAST = TW'((PAUSE_TIME > 1) ? PAUSE_TIME - 2 : 0);

  localparam logic [2:0] OP_END     = 3'd0;
  localparam logic [2:0] OP_TRACK   = 3'd1;
  localparam logic [2:0] OP_BRAKE   = 3'd2;
  localparam logic [2:0] OP_UTURN   = 3'd3;
  localparam logic [2:0] OP_REVERSE = 3'd4;
  localparam logic [2:0] OP_WAIT    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_RELEASE, S_PAUSE, S_DONE, S_FAULT
  } state_t;

  state_t        r_state, w_state;
  logic [TW-1:0] r_timer, w_timer;
  logic [2:0]    r_op, w_op;
  logic [3:0]    r_en, w_en;       // {reverse, uturn, brake, tracking} = opcode-1 bit
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_fault, w_fault;
  logic [1:0]    r_code, w_code;
  logic [2:0]    r_step, w_step;
  logic [2:0]    r_prog [8];

  logic [2:0] w_slot;
  logic [3:0] w_flags;
  logic       w_flag;
  logic       w_to;

  assign w_slot  = r_prog[r_step];
  assign w_flags = {reverse_finished, uturn_finished, brake_finished, end_of_track};
  assign w_to    = (r_timer == TO_LAST);

  // Completion flag belonging to the step in progress.
  always_comb begin
    w_flag = 1'b0;
    case (r_op)
      OP_TRACK:   w_flag = end_of_track;
      OP_BRAKE:   w_flag = brake_finished;
      OP_UTURN:   w_flag = uturn_finished;
      OP_REVERSE: w_flag = reverse_finished;
      default:    w_flag = 1'b0;
    endcase
  end

  // Program memory: loads are accepted only while no sequence is running.
  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_prog[i] <= OP_END;
    end else if (prog_we && !r_busy) begin
      r_prog[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    w_state = r_state;
    w_timer = r_timer;
    w_op    = r_op;
    w_en    = 4'b0000;
    w_done  = r_done;
    w_fault = r_fault;
    w_code  = r_code;
    w_step  = r_step;
    if (abort) begin
      w_state = S_IDLE;
      w_timer = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            w_state = S_FETCH;
            w_step  = 3'd0;
            w_done  = 1'b0;
            w_fault = 1'b0;
            w_code  = 2'b00;
            w_timer = '0;
          end
        end
        S_FETCH: begin
          // A flag still high from the previous step must clear first.
          if (w_flags != 4'b0000) begin
            if (w_to) begin
              w_state = S_FAULT;
              w_fault = 1'b1;
              w_code  = 2'b01;
            end else begin
              w_timer = r_timer + ONE;
            end
          end else begin
            case (w_slot)
              OP_END: begin
                w_state = S_DONE;
                w_done  = 1'b1;
              end
              OP_TRACK, OP_BRAKE, OP_UTURN, OP_REVERSE: begin
                w_state = S_ISSUE;
                w_op    = w_slot;
                w_en    = 4'b0001 << (w_slot - 3'd1);
                w_timer = '0;
              end
              OP_WAIT: begin
                w_state = S_PAUSE;
                w_timer = '0;
              end
              default: begin
                w_state = S_FAULT;
                w_fault = 1'b1;
                w_code  = 2'b10;
              end
            endcase
          end
        end
        S_ISSUE: begin
          if (w_to) begin
            w_state = S_FAULT;
            w_fault = 1'b1;
            w_code  = 2'b01;
          end else if (w_flag) begin
            w_state = S_RELEASE;
            w_timer = r_timer + ONE;
          end else begin
            w_en    = r_en;
            w_timer = r_timer + ONE;
          end
        end
        S_RELEASE, S_PAUSE: begin
          if (r_state == S_RELEASE && w_to) begin
            w_state = S_FAULT;
            w_fault = 1'b1;
            w_code  = 2'b01;
          end else if ((r_state == S_RELEASE && !w_flag) ||
                       (r_state == S_PAUSE && r_timer >= PAUSE_LAST)) begin
            if (r_step == 3'd7) begin
              w_state = S_DONE;
              w_done  = 1'b1;
            end else begin
              w_state = S_FETCH;
              w_step  = r_step + 3'd1;
              w_timer = '0;
            end
          end else begin
            w_timer = r_timer + ONE;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
    w_busy = !(w_state == S_IDLE || w_state == S_DONE || w_state == S_FAULT);
  end

  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_op    <= OP_END;
      r_en    <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_code  <= 2'b00;
      r_step  <= 3'd0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_op    <= w_op;
      r_en    <= w_en;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_fault <= w_fault;
      r_code  <= w_code;
      r_step  <= w_step;
    end
  end

  assign en_tracking = r_en[0];
  assign en_brake    = r_en[1];
  assign en_uturn    = r_en[2];
  assign en_reverse  = r_en[3];
  assign busy        = r_busy;
  assign done        = r_done;
  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign step        = r_step;

endmodule

// File: tb/tb_route_sequencer.sv
// tb_route_sequencer: drives route_sequencer with directed and random programs,
// a flag-responder standing in for the tracking/u-turn block, and a program-level reference model.
// The model walks the program slots to predict the enable pulse order and the final done/fault/step.
module tb_route_sequencer;
  localparam int STO = 50;
  localparam int PT  = 4;

  logic       clkus = 1'b0;
  logic       rst = 1'b1, start = 1'b0, abort = 1'b0, prog_we = 1'b0;
  logic [2:0] prog_addr = 3'd0, prog_data = 3'd0;
  logic       end_of_track, uturn_finished, brake_finished, reverse_finished;
  logic       en_tracking, en_uturn, en_brake, en_reverse;
  logic       busy, done, fault;
  logic [1:0] fault_code;
  logic [2:0] step;

  route_sequencer #(.STEP_TIMEOUT(STO), .PAUSE_TIME(PT)) dut (
    .clkus(clkus), .rst(rst), .start(start), .abort(abort),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .end_of_track(end_of_track), .uturn_finished(uturn_finished),
    .brake_finished(brake_finished), .reverse_finished(reverse_finished),
    .en_tracking(en_tracking), .en_uturn(en_uturn), .en_brake(en_brake),
    .en_reverse(en_reverse), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .step(step)
  );

  always #5 clkus = ~clkus;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Enable vector index i corresponds to opcode i+1.
  wire [3:0] en_v = {en_reverse, en_uturn, en_brake, en_tracking};

  // Responder: flag rises resp_lat cycles into an enable, clears one cycle after the enable drops.
  logic [3:0] rflag = 4'b0, stuck = 4'b0, resp_on = 4'hF;
  int resp_lat = 5;
  assign {reverse_finished, uturn_finished, brake_finished, end_of_track} = rflag | stuck;

  initial begin
    int rcnt[4];
    bit rel[4];
    for (int i = 0; i < 4; i++) begin rcnt[i] = 0; rel[i] = 0; end
    forever begin
      @(negedge clkus);
      for (int i = 0; i < 4; i++) begin
        if (en_v[i]) begin
          rcnt[i]++;
          rel[i] = 0;
          if (resp_on[i] && rcnt[i] >= resp_lat) rflag[i] = 1'b1;
        end else begin
          rcnt[i] = 0;
          if (rflag[i]) begin
            if (rel[i]) begin rflag[i] = 1'b0; rel[i] = 0; end
            else rel[i] = 1;
          end
        end
      end
    end
  end

  // Monitor: exclusivity of enables, and the order in which enables rise.
  int obs_q[$];
  logic [3:0] prev_en = 4'b0;
  initial begin
    forever begin
      @(negedge clkus);
      chk("onehot", $countones(en_v) <= 1, 1);
      chk("idle_en", (!busy && en_v != 4'b0), 0);
      for (int i = 0; i < 4; i++)
        if (en_v[i] && !prev_en[i]) obs_q.push_back(i + 1);
      prev_en = en_v;
    end
  end

  // Program mirror and reference model.
  int mirror[8];
  int pg[8];
  int exp_q[$];
  int e_done, e_fault, e_code, e_step;

  task automatic wr(input int a, input int d);
    @(negedge clkus);
    prog_we = 1'b1; prog_addr = 3'(a); prog_data = 3'(d);
    @(negedge clkus);
    prog_we = 1'b0;
    mirror[a] = d;
  endtask

  task automatic load_pg();
    for (int a = 0; a < 8; a++) wr(a, pg[a]);
  endtask

  function automatic void build_exp();
    exp_q.delete();
    e_done = 0; e_fault = 0; e_code = 0; e_step = 7;
    for (int s = 0; s < 8; s++) begin
      e_step = s;
      if (mirror[s] == 0) begin e_done = 1; return; end
      if (mirror[s] >= 6) begin e_fault = 1; e_code = 2; return; end
      if (mirror[s] != 5) exp_q.push_back(mirror[s]);
    end
    e_done = 1;
  endfunction

  int r_first, r_len;

  // Pulse start, then follow the run; cycle 1 is the edge that samples start.
  task automatic start_run(input bit poke);
    int k;
    obs_q.delete();
    r_first = 0;
    @(negedge clkus); start = 1'b1;
    @(negedge clkus); start = 1'b0;
    k = 1;
    while (busy && k < 3000) begin
      if (r_first == 0 && en_v != 4'b0) r_first = k;
      if (poke && k == 3) begin
        prog_we = 1'b1; prog_addr = 3'd3; prog_data = 3'd0;
      end else prog_we = 1'b0;
      @(negedge clkus);
      k++;
    end
    prog_we = 1'b0;
    r_len = k;
    chk("run_bound", k < 3000, 1);
  endtask

  task automatic check_model(input string tag);
    build_exp();
    chk({tag, "_npulse"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_pulse"}, obs_q[i], exp_q[i]);
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_fault"}, fault, e_fault);
    chk({tag, "_code"}, fault_code, e_code);
    chk({tag, "_step"}, step, e_step);
    chk({tag, "_en_off"}, en_v, 0);
  endtask

  task automatic wait_en_track(input string tag);
    int n = 0;
    while (!en_tracking && n < 200) begin @(negedge clkus); n++; end
    chk(tag, en_tracking, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) mirror[i] = 0;
    repeat (3) @(negedge clkus);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_step", step, 0);
    chk("rst_en", en_v, 0);
    rst = 1'b0;

    // Program RAM comes out of reset as all END.
    start_run(0);
    check_model("empty");

    // Three manoeuvres with a 5-cycle responder; enable rises on cycle 2.
    resp_lat = 5;
    pg = '{1, 2, 3, 0, 0, 0, 0, 0};
    load_pg();
    start_run(0);
    check_model("tbu");
    chk("issue_latency", r_first, 2);

    // WAIT then REVERSE: PAUSE entered on cycle 2, enable PAUSE_TIME later.
    pg = '{5, 4, 0, 0, 0, 0, 0, 0};
    load_pg();
    start_run(0);
    check_model("wait_rev");
    chk("pause_latency", r_first, 2 + PT);

    // Brake never finishes: enable held exactly STEP_TIMEOUT cycles, then fault 01.
    pg = '{2, 0, 0, 0, 0, 0, 0, 0};
    load_pg();
    resp_on = 4'b1101;
    start_run(0);
    chk("brake_to_fault", fault, 1);
    chk("brake_to_code", fault_code, 1);
    chk("brake_to_en", en_brake, 0);
    chk("brake_to_step", step, 0);
    chk("brake_hi_cycles", r_len - r_first, STO);
    resp_on = 4'hF;

    // Illegal opcode in slot 0.
    pg = '{6, 1, 0, 0, 0, 0, 0, 0};
    load_pg();
    start_run(0);
    check_model("illegal");
    chk("illegal_no_en", r_first, 0);

    // Stale uturn flag holds FETCH until it clears.
    pg = '{1, 0, 0, 0, 0, 0, 0, 0};
    load_pg();
    stuck = 4'b0100;
    obs_q.delete();
    @(negedge clkus); start = 1'b1;
    @(negedge clkus); start = 1'b0;
    repeat (10) @(negedge clkus);
    chk("stale_en", en_v, 0);
    chk("stale_busy", busy, 1);
    stuck = 4'b0000;
    n = 0;
    while (busy && n < 300) begin @(negedge clkus); n++; end
    chk("stale_bound", n < 300, 1);
    chk("stale_done", done, 1);
    chk("stale_step", step, 1);
    chk("stale_npulse", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("stale_pulse", obs_q[0], 1);

    // Abort with start in the same cycle wins; done is left as it was.
    @(negedge clkus); start = 1'b1; abort = 1'b1;
    @(negedge clkus); start = 1'b0; abort = 1'b0;
    chk("abst_busy", busy, 0);
    chk("abst_done", done, 1);
    chk("abst_fault", fault, 0);

    // Abort in the middle of an ISSUE drops the enable.
    resp_on = 4'b0000;
    @(negedge clkus); start = 1'b1;
    @(negedge clkus); start = 1'b0;
    wait_en_track("abort_issue_reached");
    repeat (3) @(negedge clkus);
    abort = 1'b1;
    @(negedge clkus); abort = 1'b0;
    chk("abort_en", en_v, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_fault", fault, 0);
    resp_on = 4'hF;

    // Stale flag that never clears: FETCH lasts STEP_TIMEOUT cycles then fault 01.
    stuck = 4'b0001;
    start_run(0);
    chk("fetch_to_fault", fault, 1);
    chk("fetch_to_code", fault_code, 1);
    chk("fetch_to_cycles", r_len, STO + 1);
    chk("fetch_to_no_en", r_first, 0);
    stuck = 4'b0000;
    repeat (3) @(negedge clkus);

    // Eight TRACK steps; a write attempted mid-run must be dropped.
    pg = '{1, 1, 1, 1, 1, 1, 1, 1};
    load_pg();
    start_run(1);
    check_model("all_track");
    start_run(0);
    check_model("ram_kept");

    // Reset in the middle of ISSUE drops the enable before the next edge.
    @(negedge clkus); start = 1'b1;
    @(negedge clkus); start = 1'b0;
    wait_en_track("rst_issue_reached");
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_en", en_tracking, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clkus); rst = 1'b0;
    for (int i = 0; i < 8; i++) mirror[i] = 0;
    repeat (3) @(negedge clkus);
    start_run(0);
    check_model("post_rst");

    // Random programs and responder latencies.
    for (int r = 0; r < 40; r++) begin
      for (int a = 0; a < 8; a++) begin
        int x;
        x = $urandom_range(0, 15);
        if (x == 0) pg[a] = 0;
        else if (x <= 3) pg[a] = 1;
        else if (x <= 6) pg[a] = 2;
        else if (x <= 9) pg[a] = 3;
        else if (x <= 12) pg[a] = 4;
        else if (x <= 14) pg[a] = 5;
        else pg[a] = 6 + $urandom_range(0, 1);
      end
      load_pg();
      resp_lat = $urandom_range(1, 8);
      repeat (3) @(negedge clkus);
      start_run(0);
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
